// File: rtl/ofs_plat_avalon_mem_rdwr_skid_reg.sv
// Split read/write Avalon memory pipeline register.
// Each request channel is an independent skid FIFO whose waitrequest is a
// plain register (FIFO full), so sink backpressure never reaches the source
// combinationally. Responses ride a fixed-length, non-stallable delay line.
module ofs_plat_avalon_mem_rdwr_skid_reg #(
    parameter int ADDR_WIDTH      = 32,
    parameter int DATA_WIDTH      = 512,
    parameter int BURST_CNT_WIDTH = 7,
    parameter int USER_WIDTH      = 1,
    parameter int RESPONSE_WIDTH  = 2,
    parameter int SKID_DEPTH      = 2,
    parameter int RSP_STAGES      = 1,
    parameter int RD_BYPASS       = 0,
    parameter int WR_BYPASS       = 0,
    localparam int RQ  = USER_WIDTH + DATA_WIDTH/8 + BURST_CNT_WIDTH + ADDR_WIDTH,
    localparam int RR  = USER_WIDTH + RESPONSE_WIDTH + DATA_WIDTH,
    localparam int WQ  = RQ + DATA_WIDTH,
    localparam int WRS = USER_WIDTH + RESPONSE_WIDTH,
    localparam int CW  = $clog2(SKID_DEPTH + 1)
) (
    input  logic           clk,
    input  logic           reset_n,

    input  logic           s_rd_read,
    input  logic [RQ-1:0]  s_rd_req,
    output logic           s_rd_waitrequest,
    output logic           s_rd_rsp_valid,
    output logic [RR-1:0]  s_rd_rsp,

    input  logic           s_wr_write,
    input  logic [WQ-1:0]  s_wr_req,
    output logic           s_wr_waitrequest,
    output logic           s_wr_rsp_valid,
    output logic [WRS-1:0] s_wr_rsp,

    output logic           m_rd_read,
    output logic [RQ-1:0]  m_rd_req,
    input  logic           m_rd_waitrequest,
    input  logic           m_rd_rsp_valid,
    input  logic [RR-1:0]  m_rd_rsp,

    output logic           m_wr_write,
    output logic [WQ-1:0]  m_wr_req,
    input  logic           m_wr_waitrequest,
    input  logic           m_wr_rsp_valid,
    input  logic [WRS-1:0] m_wr_rsp,

    output logic [CW-1:0]  rd_count,
    output logic [CW-1:0]  wr_count
);
    localparam int PTRW = $clog2(SKID_DEPTH);

    // Channel 0 is read, channel 1 is write; the logic is identical apart
    // from payload widths and the bypass selection.
    for (genvar ch = 0; ch < 2; ch++) begin : g_ch
        localparam int QW  = (ch == 0) ? RQ : WQ;
        localparam int PW  = (ch == 0) ? RR : WRS;
        localparam bit BYP = (ch == 0) ? (RD_BYPASS != 0) : (WR_BYPASS != 0);

        logic          w_s_vld, w_s_wait, w_m_vld, w_m_wait;
        logic [QW-1:0] w_s_req, w_m_req;
        logic          w_rin_vld, w_rout_vld;
        logic [PW-1:0] w_rin, w_rout;
        logic [CW-1:0] w_count;

        if (ch == 0) begin : g_rd
            assign w_s_vld          = s_rd_read;
            assign w_s_req          = s_rd_req;
            assign s_rd_waitrequest = w_s_wait;
            assign m_rd_read        = w_m_vld;
            assign m_rd_req         = w_m_req;
            assign w_m_wait         = m_rd_waitrequest;
            assign w_rin_vld        = m_rd_rsp_valid;
            assign w_rin            = m_rd_rsp;
            assign s_rd_rsp_valid   = w_rout_vld;
            assign s_rd_rsp         = w_rout;
            assign rd_count         = w_count;
        end else begin : g_wr
            assign w_s_vld          = s_wr_write;
            assign w_s_req          = s_wr_req;
            assign s_wr_waitrequest = w_s_wait;
            assign m_wr_write       = w_m_vld;
            assign m_wr_req         = w_m_req;
            assign w_m_wait         = m_wr_waitrequest;
            assign w_rin_vld        = m_wr_rsp_valid;
            assign w_rin            = m_wr_rsp;
            assign s_wr_rsp_valid   = w_rout_vld;
            assign s_wr_rsp         = w_rout;
            assign wr_count         = w_count;
        end

        if (BYP) begin : g_byp
            // Straight wires; backpressure passes through untouched.
            assign w_m_vld  = w_s_vld;
            assign w_m_req  = w_s_req;
            assign w_s_wait = w_m_wait;
            assign w_count  = '0;
        end else begin : g_fifo
            logic [QW-1:0]   r_mem [SKID_DEPTH];
            logic [PTRW-1:0] r_wptr, r_rptr;
            logic [CW-1:0]   r_count;
            logic            r_wait;
            logic            w_push, w_pop;
            logic [CW-1:0]   w_count_nxt;

            // r_wait is the full flag, so a full FIFO can never be pushed.
            assign w_push      = w_s_vld && !r_wait;
            assign w_pop       = (r_count != '0) && !w_m_wait;
            assign w_count_nxt = r_count + CW'(w_push) - CW'(w_pop);

            // Pointers, occupancy and registered waitrequest. Waitrequest
            // resets high and drops on the first edge out of reset.
            always_ff @(posedge clk or negedge reset_n) begin
                if (!reset_n) begin
                    r_wptr  <= '0;
                    r_rptr  <= '0;
                    r_count <= '0;
                    r_wait  <= 1'b1;
                end else begin
                    if (w_push) r_wptr <= r_wptr + PTRW'(1);
                    if (w_pop)  r_rptr <= r_rptr + PTRW'(1);
                    r_count <= w_count_nxt;
                    r_wait  <= (w_count_nxt == CW'(SKID_DEPTH));
                end
            end

            // Payload storage; contents are don't-care until pushed.
            always_ff @(posedge clk) begin
                if (w_push) r_mem[r_wptr] <= w_s_req;
            end

            assign w_m_vld  = (r_count != '0);
            assign w_m_req  = r_mem[r_rptr];
            assign w_s_wait = r_wait;
            assign w_count  = r_count;
        end

        if (RSP_STAGES == 0) begin : g_rsp_wire
            assign w_rout_vld = w_rin_vld;
            assign w_rout     = w_rin;
        end else begin : g_rsp_pipe
            logic [RSP_STAGES-1:0] r_vld_pipe;
            logic [PW-1:0]         r_dat_pipe [RSP_STAGES];

            // Response valid shift register; cleared so reset drops in-flight responses.
            always_ff @(posedge clk or negedge reset_n) begin
                if (!reset_n) begin
                    r_vld_pipe <= '0;
                end else begin
                    r_vld_pipe[0] <= w_rin_vld;
                    for (int i = 1; i < RSP_STAGES; i++) r_vld_pipe[i] <= r_vld_pipe[i-1];
                end
            end

            // Response payload delay line; meaningful only alongside its valid.
            always_ff @(posedge clk) begin
                r_dat_pipe[0] <= w_rin;
                for (int i = 1; i < RSP_STAGES; i++) r_dat_pipe[i] <= r_dat_pipe[i-1];
            end

            assign w_rout_vld = r_vld_pipe[RSP_STAGES-1];
            assign w_rout     = r_dat_pipe[RSP_STAGES-1];
        end
    end
endmodule

// File: tb/tb_ofs_plat_avalon_mem_rdwr_skid_reg.sv
// Bench: a queue-based model of both channels plus a response delay line,
// checked every cycle against a registered instance (depth 4, 3 response
// stages) and a read-bypass instance (depth 2, response wires).
module tb_ofs_plat_avalon_mem_rdwr_skid_reg;
    localparam int DEPTH = 4;
    localparam int NST   = 3;

    logic clk = 1'b0;
    logic reset_n = 1'b1;
    always #5 clk = ~clk;

    logic        s_rd_read = 0, s_wr_write = 0;
    logic [43:0] s_rd_req = '0;
    logic [75:0] s_wr_req = '0;
    logic        m_rd_wait = 0, m_wr_wait = 0, m_rd_rv = 0, m_wr_rv = 0;
    logic [34:0] m_rd_rsp = '0;
    logic [2:0]  m_wr_rsp = '0;
    logic        b_m_wr_wait = 1'b0;

    logic        a_s_rd_wait, a_s_rd_rv, a_s_wr_wait, a_s_wr_rv, a_m_rd_read, a_m_wr_write;
    logic [34:0] a_s_rd_rsp;
    logic [2:0]  a_s_wr_rsp, a_rd_count, a_wr_count;
    logic [43:0] a_m_rd_req;
    logic [75:0] a_m_wr_req;

    logic        b_s_rd_wait, b_s_rd_rv, b_s_wr_wait, b_s_wr_rv, b_m_rd_read, b_m_wr_write;
    logic [34:0] b_s_rd_rsp;
    logic [2:0]  b_s_wr_rsp;
    logic [1:0]  b_rd_count, b_wr_count;
    logic [43:0] b_m_rd_req;
    logic [75:0] b_m_wr_req;

    ofs_plat_avalon_mem_rdwr_skid_reg #(
        .ADDR_WIDTH(32), .DATA_WIDTH(32), .BURST_CNT_WIDTH(7), .USER_WIDTH(1),
        .RESPONSE_WIDTH(2), .SKID_DEPTH(DEPTH), .RSP_STAGES(NST),
        .RD_BYPASS(0), .WR_BYPASS(0)
    ) dut (
        .clk(clk), .reset_n(reset_n),
        .s_rd_read(s_rd_read), .s_rd_req(s_rd_req), .s_rd_waitrequest(a_s_rd_wait),
        .s_rd_rsp_valid(a_s_rd_rv), .s_rd_rsp(a_s_rd_rsp),
        .s_wr_write(s_wr_write), .s_wr_req(s_wr_req), .s_wr_waitrequest(a_s_wr_wait),
        .s_wr_rsp_valid(a_s_wr_rv), .s_wr_rsp(a_s_wr_rsp),
        .m_rd_read(a_m_rd_read), .m_rd_req(a_m_rd_req), .m_rd_waitrequest(m_rd_wait),
        .m_rd_rsp_valid(m_rd_rv), .m_rd_rsp(m_rd_rsp),
        .m_wr_write(a_m_wr_write), .m_wr_req(a_m_wr_req), .m_wr_waitrequest(m_wr_wait),
        .m_wr_rsp_valid(m_wr_rv), .m_wr_rsp(m_wr_rsp),
        .rd_count(a_rd_count), .wr_count(a_wr_count)
    );

    ofs_plat_avalon_mem_rdwr_skid_reg #(
        .ADDR_WIDTH(32), .DATA_WIDTH(32), .BURST_CNT_WIDTH(7), .USER_WIDTH(1),
        .RESPONSE_WIDTH(2), .SKID_DEPTH(2), .RSP_STAGES(0),
        .RD_BYPASS(1), .WR_BYPASS(0)
    ) dut_b (
        .clk(clk), .reset_n(reset_n),
        .s_rd_read(s_rd_read), .s_rd_req(s_rd_req), .s_rd_waitrequest(b_s_rd_wait),
        .s_rd_rsp_valid(b_s_rd_rv), .s_rd_rsp(b_s_rd_rsp),
        .s_wr_write(s_wr_write), .s_wr_req(s_wr_req), .s_wr_waitrequest(b_s_wr_wait),
        .s_wr_rsp_valid(b_s_wr_rv), .s_wr_rsp(b_s_wr_rsp),
        .m_rd_read(b_m_rd_read), .m_rd_req(b_m_rd_req), .m_rd_waitrequest(m_rd_wait),
        .m_rd_rsp_valid(m_rd_rv), .m_rd_rsp(m_rd_rsp),
        .m_wr_write(b_m_wr_write), .m_wr_req(b_m_wr_req), .m_wr_waitrequest(b_m_wr_wait),
        .m_wr_rsp_valid(m_wr_rv), .m_wr_rsp(m_wr_rsp),
        .rd_count(b_rd_count), .wr_count(b_wr_count)
    );

    int n_cmp = 0, n_bad = 0;
    task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    typedef struct packed { logic rv; logic [34:0] rr; logic wv; logic [2:0] wr; } rsp_t;
    logic [43:0] rq[$];
    logic [75:0] wq[$];
    rsp_t        rh[$];
    bit          pend = 1'b1;      // in reset / before first edge after reset
    int          rd_push_n = 0, wr_push_n = 0;
    bit          bw_v = 1'b0;      // bypass instance: write presented this cycle
    logic [75:0] bw_req = '0;

    function automatic bit e_rd_wait(); return pend || (rq.size() == DEPTH); endfunction
    function automatic bit e_wr_wait(); return pend || (wq.size() == DEPTH); endfunction

    always @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            rq.delete(); wq.delete(); rh.delete();
            pend = 1'b1; bw_v = 1'b0;
        end else begin
            bit rpush, rpop, wpush, wpop;
            rsp_t r;
            rpush = s_rd_read && !e_rd_wait();
            rpop  = (rq.size() != 0) && !m_rd_wait;
            wpush = s_wr_write && !e_wr_wait();
            wpop  = (wq.size() != 0) && !m_wr_wait;
            if (rpop) void'(rq.pop_front());
            if (rpush) begin rq.push_back(s_rd_req); rd_push_n++; end
            if (wpop) void'(wq.pop_front());
            if (wpush) begin wq.push_back(s_wr_req); wr_push_n++; end
            r.rv = m_rd_rv; r.rr = m_rd_rsp; r.wv = m_wr_rv; r.wr = m_wr_rsp;
            rh.push_back(r);
            if (rh.size() > NST) void'(rh.pop_front());
            bw_v   = !pend && s_wr_write;
            bw_req = s_wr_req;
            pend   = 1'b0;
        end
    end

    // ---------------- per-cycle compare ----------------
    always @(negedge clk) begin
        bit erv, ewv;
        #1;
        chk("rd_wait", 128'(a_s_rd_wait), 128'(e_rd_wait()));
        chk("rd_read", 128'(a_m_rd_read), 128'(rq.size() != 0));
        if (rq.size() != 0) chk("rd_req", 128'(a_m_rd_req), 128'(rq[0]));
        chk("rd_count", 128'(a_rd_count), 128'(rq.size()));
        chk("wr_wait", 128'(a_s_wr_wait), 128'(e_wr_wait()));
        chk("wr_write", 128'(a_m_wr_write), 128'(wq.size() != 0));
        if (wq.size() != 0) chk("wr_req", 128'(a_m_wr_req), 128'(wq[0]));
        chk("wr_count", 128'(a_wr_count), 128'(wq.size()));
        erv = (rh.size() == NST) && rh[0].rv;
        ewv = (rh.size() == NST) && rh[0].wv;
        chk("rd_rsp_valid", 128'(a_s_rd_rv), 128'(erv));
        if (erv) chk("rd_rsp", 128'(a_s_rd_rsp), 128'(rh[0].rr));
        chk("wr_rsp_valid", 128'(a_s_wr_rv), 128'(ewv));
        if (ewv) chk("wr_rsp", 128'(a_s_wr_rsp), 128'(rh[0].wr));
        if (reset_n) begin
            chk("byp_rd_read", 128'(b_m_rd_read), 128'(s_rd_read));
            if (s_rd_read) chk("byp_rd_req", 128'(b_m_rd_req), 128'(s_rd_req));
            chk("byp_rd_wait", 128'(b_s_rd_wait), 128'(m_rd_wait));
            chk("byp_rd_count", 128'(b_rd_count), 128'(0));
            chk("byp_rd_rsp_valid", 128'(b_s_rd_rv), 128'(m_rd_rv));
            if (m_rd_rv) chk("byp_rd_rsp", 128'(b_s_rd_rsp), 128'(m_rd_rsp));
            chk("byp_wr_write", 128'(b_m_wr_write), 128'(bw_v));
            if (bw_v) chk("byp_wr_req", 128'(b_m_wr_req), 128'(bw_req));
            chk("byp_wr_count", 128'(b_wr_count), 128'(bw_v));
            chk("byp_wr_wait", 128'(b_s_wr_wait), 128'(pend));
            chk("byp_wr_rsp_valid", 128'(b_s_wr_rv), 128'(m_wr_rv));
        end
    end

    task automatic step(); @(negedge clk); endtask

    // ---------------- stimulus + literal expectations ----------------
    initial begin
        int base, n, nxt;
        #1 reset_n = 1'b0;
        #11;
        chk("rst_rd_wait", 128'(a_s_rd_wait), 128'(1));
        chk("rst_wr_wait", 128'(a_s_wr_wait), 128'(1));
        chk("rst_rd_read", 128'(a_m_rd_read), 128'(0));
        chk("rst_wr_count", 128'(a_wr_count), 128'(0));
        chk("rst_rd_rsp_valid", 128'(a_s_rd_rv), 128'(0));
        step(); #2 reset_n = 1'b1;
        step();
        chk("first_edge_wait", 128'(a_s_rd_wait), 128'(0));

        // 8 back-to-back reads, sink never stalls
        for (int k = 0; k < 8; k++) begin
            s_rd_read = 1'b1;
            s_rd_req  = {1'b0, 4'hF, 7'd1, 32'(k)};
            step();
            chk("b2b_read", 128'(a_m_rd_read), 128'(1));
            chk("b2b_addr", 128'(a_m_rd_req[31:0]), 128'(k));
            chk("b2b_count", 128'(a_rd_count), 128'(1));
            chk("b2b_wait", 128'(a_s_rd_wait), 128'(0));
        end
        s_rd_read = 1'b0;

        // Sink stalled: six writes offered, four fit
        base = wr_push_n;
        m_wr_wait = 1'b1;
        repeat (7) begin
            n = wr_push_n - base;
            s_wr_write = (n < 6);
            s_wr_req   = {1'b0, 4'hF, 7'd1, 32'h1000 + 32'(n), 32'(n)};
            step();
        end
        chk("stall_count", 128'(a_wr_count), 128'(4));
        chk("stall_wait", 128'(a_s_wr_wait), 128'(1));
        m_wr_wait = 1'b0;
        nxt = 0;
        repeat (12) begin
            n = wr_push_n - base;
            s_wr_write = (n < 6);
            s_wr_req   = {1'b0, 4'hF, 7'd1, 32'h1000 + 32'(n), 32'(n)};
            if (a_m_wr_write) begin
                chk("drain_order", 128'(a_m_wr_req[31:0]), 128'(nxt));
                nxt++;
            end
            step();
        end
        chk("drain_total", 128'(nxt), 128'(6));
        chk("drain_count", 128'(a_wr_count), 128'(0));

        // Response pulses through 3 stages
        for (int p = 0; p < 2; p++) begin
            m_rd_rv = 1'b1; m_rd_rsp = {1'b0, 2'b00, 32'hA5};
            m_wr_rv = 1'b1; m_wr_rsp = 3'b110;
            step();
            m_rd_rv = 1'b0; m_wr_rv = 1'b0;
            chk("rsp_lat1", 128'(a_s_rd_rv), 128'(0));
            step();
            chk("rsp_lat2", 128'(a_s_rd_rv), 128'(0));
            step();
            chk("rsp_lat3_rd", 128'(a_s_rd_rv), 128'(1));
            chk("rsp_lat3_rdata", 128'(a_s_rd_rsp), 128'(35'h0_0000_00A5));
            chk("rsp_lat3_wr", 128'(a_s_wr_rv), 128'(1));
            chk("rsp_lat3_wdata", 128'(a_s_wr_rsp), 128'(3'b110));
            step();
            chk("rsp_lat4", 128'(a_s_rd_rv), 128'(0));
        end

        // Random traffic; first 40 cycles: toggling sink, burstcount 4
        for (int c = 0; c < 600; c++) begin
            m_rd_wait = (c < 40) ? c[0] : ($urandom_range(0, 3) == 0);
            m_wr_wait = ($urandom_range(0, 2) == 0);
            if (!(s_rd_read && e_rd_wait())) begin
                s_rd_read = (c < 40) ? 1'b1 : 1'($urandom_range(0, 1));
                s_rd_req  = {1'($urandom), 4'($urandom),
                             (c < 40) ? 7'd4 : 7'($urandom), 32'(rd_push_n)};
            end
            if (!(s_wr_write && e_wr_wait())) begin
                s_wr_write = 1'($urandom_range(0, 1));
                s_wr_req   = {12'($urandom), 32'(wr_push_n), 32'($urandom)};
            end
            m_rd_rv  = 1'($urandom_range(0, 1));
            m_rd_rsp = 35'({$urandom, $urandom});
            m_wr_rv  = 1'($urandom_range(0, 1));
            m_wr_rsp = 3'($urandom);
            step();
        end

        // Quiesce, then reset with two writes queued and a response in flight
        s_rd_read = 0; s_wr_write = 0; m_rd_rv = 0; m_wr_rv = 0;
        m_rd_wait = 0; m_wr_wait = 0;
        repeat (8) step();
        m_wr_wait = 1'b1;
        for (int k = 0; k < 2; k++) begin
            s_wr_write = 1'b1;
            s_wr_req   = {12'h0, 32'h2000, 32'(k)};
            step();
        end
        s_wr_write = 1'b0;
        m_rd_rv = 1'b1; m_rd_rsp = 35'h1234;
        step();
        m_rd_rv = 1'b0;
        chk("pre_rst_wr_count", 128'(a_wr_count), 128'(2));
        #2 reset_n = 1'b0;
        #1;
        chk("mid_rst_rd_wait", 128'(a_s_rd_wait), 128'(1));
        chk("mid_rst_wr_wait", 128'(a_s_wr_wait), 128'(1));
        chk("mid_rst_wr_write", 128'(a_m_wr_write), 128'(0));
        chk("mid_rst_rd_read", 128'(a_m_rd_read), 128'(0));
        chk("mid_rst_wr_count", 128'(a_wr_count), 128'(0));
        chk("mid_rst_rd_count", 128'(a_rd_count), 128'(0));
        chk("mid_rst_rsp_valid", 128'(a_s_rd_rv), 128'(0));
        m_wr_wait = 1'b0;
        step(); #2 reset_n = 1'b1;
        step();
        chk("post_rst_wait", 128'(a_s_wr_wait), 128'(0));
        chk("post_rst_no_stale", 128'(a_m_wr_write), 128'(0));
        chk("post_rst_no_rsp", 128'(a_s_rd_rv), 128'(0));
        repeat (4) step();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
